dramcon_mport: RTL and testbench
================================

Name: dramcon_mport

Overview:
- Multi-port successor of the DRAM read/write port controller.
- Sits between NPORT user-logic requesters and the MIG DDR3 application interface (app_*); the MIG core is instantiated outside this block.
- Round-robin arbitrates whole load/store bursts of D_ELEM blocks. Walks the address with a configurable stride and wrap point, then routes write data from, and read data to, the granted port only.

Parameters:
- NPORT, 4, number of requester ports (2..8)
- DATA_W, 512, app data width
- ADDR_W, 28, app address width
- ELEM_W, 32, element-count width
- ADDR_STRIDE, 8, address increment per block
- MEM_LAST_ADDR, 28'h7FFFFF8, last block address; the next block after it is 0

Ports:
- CLK  in  1  single clock (MIG ui_clk)
- RST  in  1  synchronous, active-high reset
- D_REQ  in  2*NPORT  per port: 0 none, 1 read, 2 write, 3 treated as none
- D_INITADR  in  ADDR_W*NPORT  per-port start address
- D_ELEM  in  ELEM_W*NPORT  per-port block count
- D_DIN  in  DATA_W*NPORT  per-port write data
- D_GNT  out  NPORT  one-cycle pulse when that port's request is accepted
- D_W  out  NPORT  write-data consume strobe
- D_DOUT  out  DATA_W  read data, shared by all ports
- D_DOUTEN  out  NPORT  read-data valid for that port
- D_BUSY  out  NPORT  that port's burst is in service
- app_addr  out  ADDR_W  MIG command address
- app_cmd  out  3  MIG command
- app_en  out  1  MIG command valid
- app_wdf_data  out  DATA_W  MIG write data
- app_wdf_wren  out  1  MIG write-data valid
- app_wdf_end  out  1  MIG write-data end
- app_rdy  in  1  MIG command ready
- app_wdf_rdy  in  1  MIG write-data ready
- app_rd_data  in  DATA_W  MIG read data
- app_rd_data_valid  in  1  MIG read-data valid

Behaviour:
- States: IDLE, READ, WRITE. Reset values: state IDLE, rr pointer 0; D_GNT, D_DOUTEN, D_BUSY, D_DOUT, app_addr, app_cmd 0; app_en, app_wdf_wren 0.
- IDLE arbitration: requesters with D_REQ 1 or 2 compete. Search order starts at the port after the last granted one (port 0 first after reset).
- On a win: D_GNT[i] pulses for one cycle. The block latches addr = D_INITADR[i], cmd_rem = data_rem = D_ELEM[i], owner = i, and sets app_cmd to 1 for a read or 0 for a write. It then enters READ or WRITE, and app_en is asserted on the next cycle.
- Requesters hold D_REQ until they see D_GNT, then drop it. Any D_REQ still present in the cycle after D_GNT is treated as a new request.
- D_ELEM = 0: D_GNT still pulses, the block stays in IDLE, and no app_en is issued. The rr pointer still advances.
- D_BUSY[owner] = 1 while the state is not IDLE.
- READ, command side:
  - app_en = (cmd_rem != 0).
  - On app_en && app_rdy: cmd_rem decrements; addr becomes 0 if it equals MEM_LAST_ADDR, otherwise addr + ADDR_STRIDE.
- READ, data side:
  - On app_rd_data_valid: D_DOUT <= app_rd_data and D_DOUTEN[owner] <= 1 one cycle later (registered); data_rem decrements.
  - When data_rem reaches 0 the block returns to IDLE.
- Command issue and data return may coincide in the same cycle; both counters update independently.
- WRITE: wr_fire = app_rdy && app_wdf_rdy && (cmd_rem != 0).
  - app_en, app_wdf_wren, app_wdf_end and D_W[owner] all equal wr_fire, combinationally.
  - app_wdf_data = D_DIN[owner]; the owner must present the current element until D_W.
  - Each fire decrements cmd_rem and advances addr with the same wrap rule as READ.
  - When cmd_rem reaches 0 the block returns to IDLE.
- At most one burst is in service; after each burst there is at least one IDLE cycle.
- Non-owner D_W, D_DOUTEN and D_GNT are always 0.
- Counters are ELEM_W bits wide. Address arithmetic is ADDR_W bits and never overflows, thanks to the wrap rule.
- Reset mid-burst: the block returns to IDLE on the next edge and all outputs take their reset values.
- Reads still returning from the MIG after a reset are dropped: D_DOUTEN stays 0 because no owner is in READ.

Decomposition:
- Shared package (define file) holds:
  - DRAM_REQ_READ and DRAM_REQ_WRITE request encodings
  - DRAM_CMD_READ and DRAM_CMD_WRITE command encodings
  - APPDATA_WIDTH, APPADDR_WIDTH and MEM_LAST_ADDR defaults
- Sub-module rr_arbiter (NPORT request vector plus last-grant pointer in; one-hot grant and index out; combinational, with pointer update on grant) is natural; the remainder is a single FSM.

Test Plan:
- Port 2 reads 4 blocks from 0x100 with app_rdy held at 1 → app_addr sequence 0x100, 0x108, 0x110, 0x118. Four read returns → D_DOUTEN[2] pulses 4 times; D_BUSY[2] then drops.
- Port 0 writes 3 blocks with app_wdf_rdy toggling 1,0,1,0,1 → exactly 3 D_W[0] pulses, each coincident with app_en = app_wdf_wren = 1; the data matches D_DIN[0] at each strobe.
- All 4 ports request simultaneously, each with D_ELEM = 1 → grant order 0, 1, 2, 3. A repeat request from port 0 right after port 3's burst → port 0 is granted next.
- Read starting at MEM_LAST_ADDR - 8 for 3 blocks → addresses MEM_LAST_ADDR - 8, MEM_LAST_ADDR, 0.
- D_ELEM = 0 write on port 1 → one D_GNT[1] pulse, no app_en, and D_BUSY[1] stays 0.
- RST asserted after 2 of 5 read returns → the next cycle is IDLE with all outputs 0; the remaining 3 returns produce no D_DOUTEN.

Source files
------------

// File: rtl/dramcon_mport_pkg.sv
// Shared encodings and defaults for the multi-port DRAM controller front end.
package dramcon_mport_pkg;

    // Requester-side burst request codes (3 is treated as no request)
    localparam logic [1:0] DRAM_REQ_NONE  = 2'd0;
    localparam logic [1:0] DRAM_REQ_READ  = 2'd1;
    localparam logic [1:0] DRAM_REQ_WRITE = 2'd2;

    // MIG application-interface command codes
    localparam logic [2:0] DRAM_CMD_WRITE = 3'b000;
    localparam logic [2:0] DRAM_CMD_READ  = 3'b001;

    // Default MIG interface geometry
    localparam int APPDATA_WIDTH = 512;
    localparam int APPADDR_WIDTH = 28;
    localparam logic [27:0] DEFAULT_MEM_LAST_ADDR = 28'h7FFFFF8;

    // Burst service state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } dram_state_t;

endpackage

// File: rtl/dramcon_mport_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward, wrapping,
// and reports the first requester plus the pointer to use after it.
module dramcon_mport_rr_arbiter #(
    parameter int NPORT = 4,
    parameter int IDX_W = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NPORT-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] ptr_nxt
);

    int               cand_v;
    logic [IDX_W-1:0] cand_s;

    // Pick the first active request at or after ptr, wrapping at NPORT
    always_comb begin
        gnt       = {NPORT{1'b0}};
        gnt_idx   = {IDX_W{1'b0}};
        gnt_valid = 1'b0;
        cand_v    = 0;
        cand_s    = {IDX_W{1'b0}};
        for (int k = 0; k < NPORT; k++) begin
            cand_v = int'(ptr) + k;
            cand_v = (cand_v >= NPORT) ? (cand_v - NPORT) : cand_v;
            cand_s = IDX_W'(cand_v);
            if (req[cand_s] && !gnt_valid) begin
                gnt[cand_s] = 1'b1;
                gnt_idx     = cand_s;
                gnt_valid   = 1'b1;
            end else begin
                gnt_valid   = gnt_valid;
            end
        end
        ptr_nxt = (gnt_idx == IDX_W'(NPORT - 1)) ? {IDX_W{1'b0}} : (gnt_idx + IDX_W'(1'b1));
    end

endmodule

// File: rtl/dramcon_mport.sv
// Multi-port DRAM burst controller: round-robin grants whole read/write
// bursts to one requester and drives the MIG application interface for it.
module dramcon_mport
    import dramcon_mport_pkg::*;
#(
    parameter int NPORT       = 4,
    parameter int DATA_W      = APPDATA_WIDTH,
    parameter int ADDR_W      = APPADDR_WIDTH,
    parameter int ELEM_W      = 32,
    parameter int ADDR_STRIDE = 8,
    parameter logic [ADDR_W-1:0] MEM_LAST_ADDR = DEFAULT_MEM_LAST_ADDR
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [2*NPORT-1:0]       D_REQ,
    input  logic [ADDR_W*NPORT-1:0]  D_INITADR,
    input  logic [ELEM_W*NPORT-1:0]  D_ELEM,
    input  logic [DATA_W*NPORT-1:0]  D_DIN,
    output logic [NPORT-1:0]         D_GNT,
    output logic [NPORT-1:0]         D_W,
    output logic [DATA_W-1:0]        D_DOUT,
    output logic [NPORT-1:0]         D_DOUTEN,
    output logic [NPORT-1:0]         D_BUSY,
    output logic [ADDR_W-1:0]        app_addr,
    output logic [2:0]               app_cmd,
    output logic                     app_en,
    output logic [DATA_W-1:0]        app_wdf_data,
    output logic                     app_wdf_wren,
    output logic                     app_wdf_end,
    input  logic                     app_rdy,
    input  logic                     app_wdf_rdy,
    input  logic [DATA_W-1:0]        app_rd_data,
    input  logic                     app_rd_data_valid
);

    localparam int IDX_W = $clog2(NPORT);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(ADDR_STRIDE);
    localparam logic [ELEM_W-1:0] ELEM_ZERO = {ELEM_W{1'b0}};
    localparam logic [ELEM_W-1:0] ELEM_ONE  = ELEM_W'(1'b1);
    localparam logic [NPORT-1:0]  PORT_ONE  = NPORT'(1'b1);

    dram_state_t       state_r, state_nxt_s;
    logic [IDX_W-1:0]  ptr_r, owner_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ELEM_W-1:0] cmd_rem_r, data_rem_r;
    logic [NPORT-1:0]  gnt_r, douten_r;
    logic [DATA_W-1:0] dout_r;
    logic [2:0]        app_cmd_r;

    logic [1:0]        req_code_s [NPORT];
    logic [ADDR_W-1:0] initadr_s  [NPORT];
    logic [ELEM_W-1:0] elem_s     [NPORT];
    logic [DATA_W-1:0] din_s      [NPORT];

    logic [NPORT-1:0]  req_valid_s, arb_req_s, arb_gnt_s, owner_oh_s;
    logic [IDX_W-1:0]  arb_idx_s, arb_ptr_nxt_s;
    logic              arb_valid_s, arb_en_s, win_write_s;
    logic              rd_en_s, wr_fire_s, cmd_fire_s, rd_ret_s;

    // Next block address, wrapping to 0 after the last block
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a == MEM_LAST_ADDR) begin
            next_addr = {ADDR_W{1'b0}};
        end else begin
            next_addr = a + ADDR_STEP;
        end
    endfunction

    for (genvar g = 0; g < NPORT; g++) begin : g_unpack
        assign req_code_s[g]  = D_REQ[2*g +: 2];
        assign initadr_s[g]   = D_INITADR[ADDR_W*g +: ADDR_W];
        assign elem_s[g]      = D_ELEM[ELEM_W*g +: ELEM_W];
        assign din_s[g]       = D_DIN[DATA_W*g +: DATA_W];
        assign req_valid_s[g] = (req_code_s[g] == DRAM_REQ_READ) || (req_code_s[g] == DRAM_REQ_WRITE);
    end

    // Arbitrate only in IDLE, and not in the grant-pulse cycle: the winner
    // still holds D_REQ there and must not be granted twice.
    assign arb_en_s  = (state_r == ST_IDLE) && (gnt_r == {NPORT{1'b0}});
    assign arb_req_s = req_valid_s & {NPORT{arb_en_s}};

    dramcon_mport_rr_arbiter #(
        .NPORT (NPORT),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (arb_req_s),
        .ptr       (ptr_r),
        .gnt       (arb_gnt_s),
        .gnt_idx   (arb_idx_s),
        .gnt_valid (arb_valid_s),
        .ptr_nxt   (arb_ptr_nxt_s)
    );

    assign win_write_s = (req_code_s[arb_idx_s] == DRAM_REQ_WRITE);
    assign owner_oh_s  = PORT_ONE << owner_r;
    assign rd_en_s     = (state_r == ST_READ) && (cmd_rem_r != ELEM_ZERO);
    assign wr_fire_s   = (state_r == ST_WRITE) && app_rdy && app_wdf_rdy && (cmd_rem_r != ELEM_ZERO);
    assign cmd_fire_s  = (rd_en_s && app_rdy) || wr_fire_s;
    assign rd_ret_s    = (state_r == ST_READ) && app_rd_data_valid;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: zero-length bursts stay in IDLE, reads end on the last
    // return, writes end on the last accepted command
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s && (elem_s[arb_idx_s] != ELEM_ZERO)) begin
                    state_nxt_s = win_write_s ? ST_WRITE : ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_ret_s && (data_rem_r == ELEM_ONE)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_WRITE: begin
                if (wr_fire_s && (cmd_rem_r == ELEM_ONE)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Burst context: latch on a win, walk the address per accepted command,
    // register read data toward the owner
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_r      <= {IDX_W{1'b0}};
            owner_r    <= {IDX_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            cmd_rem_r  <= ELEM_ZERO;
            data_rem_r <= ELEM_ZERO;
            gnt_r      <= {NPORT{1'b0}};
            douten_r   <= {NPORT{1'b0}};
            dout_r     <= {DATA_W{1'b0}};
            app_cmd_r  <= 3'b000;
        end else begin
            gnt_r    <= arb_valid_s ? arb_gnt_s : {NPORT{1'b0}};
            douten_r <= rd_ret_s ? owner_oh_s : {NPORT{1'b0}};
            if (rd_ret_s) begin
                dout_r     <= app_rd_data;
                data_rem_r <= data_rem_r - ELEM_ONE;
            end
            if (arb_valid_s) begin
                ptr_r      <= arb_ptr_nxt_s;
                owner_r    <= arb_idx_s;
                addr_r     <= initadr_s[arb_idx_s];
                cmd_rem_r  <= elem_s[arb_idx_s];
                data_rem_r <= elem_s[arb_idx_s];
                app_cmd_r  <= win_write_s ? DRAM_CMD_WRITE : DRAM_CMD_READ;
            end else if (cmd_fire_s) begin
                cmd_rem_r  <= cmd_rem_r - ELEM_ONE;
                addr_r     <= next_addr(addr_r);
            end
        end
    end

    // Command/write strobes follow the current state and MIG readiness
    always_comb begin
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        D_W          = {NPORT{1'b0}};
        case (state_r)
            ST_READ: begin
                app_en = rd_en_s;
            end
            ST_WRITE: begin
                app_en       = wr_fire_s;
                app_wdf_wren = wr_fire_s;
                app_wdf_end  = wr_fire_s;
                D_W          = wr_fire_s ? owner_oh_s : {NPORT{1'b0}};
            end
            default: begin
                app_en = 1'b0;
            end
        endcase
        D_BUSY = (state_r != ST_IDLE) ? owner_oh_s : {NPORT{1'b0}};
    end

    assign D_GNT        = gnt_r;
    assign D_DOUTEN     = douten_r;
    assign D_DOUT       = dout_r;
    assign app_addr     = addr_r;
    assign app_cmd      = app_cmd_r;
    assign app_wdf_data = din_s[owner_r];

endmodule

// File: tb/tb_dramcon_mport.sv
// Directed bench for dramcon_mport: grants, address walk, wrap, write
// handshake, round-robin order, zero-length bursts and mid-burst reset.
module tb_dramcon_mport;

    localparam int NPORT  = 4;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 28;
    localparam int ELEM_W = 32;
    localparam logic [ADDR_W-1:0] LAST = 28'h7FFFFF8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [2*NPORT-1:0]      d_req;
    logic [ADDR_W*NPORT-1:0] d_initadr;
    logic [ELEM_W*NPORT-1:0] d_elem;
    logic [DATA_W*NPORT-1:0] d_din;
    logic [NPORT-1:0]        d_gnt, d_w, d_douten, d_busy;
    logic [DATA_W-1:0]       d_dout;
    logic [ADDR_W-1:0]       app_addr;
    logic [2:0]              app_cmd;
    logic                    app_en, app_wdf_wren, app_wdf_end;
    logic [DATA_W-1:0]       app_wdf_data;
    logic                    app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic [DATA_W-1:0]       app_rd_data;

    int checks = 0;
    int errors = 0;

    dramcon_mport #(
        .NPORT(NPORT), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ELEM_W(ELEM_W),
        .ADDR_STRIDE(8), .MEM_LAST_ADDR(LAST)
    ) dut (
        .CLK(clk), .RST(rst),
        .D_REQ(d_req), .D_INITADR(d_initadr), .D_ELEM(d_elem), .D_DIN(d_din),
        .D_GNT(d_gnt), .D_W(d_w), .D_DOUT(d_dout), .D_DOUTEN(d_douten), .D_BUSY(d_busy),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input logic [31:0] tag);
        pat = {16{tag}};
    endfunction

    task automatic set_port(input int p, input logic [1:0] req,
                            input logic [ADDR_W-1:0] adr, input logic [ELEM_W-1:0] elem);
        d_req[2*p +: 2]               = req;
        d_initadr[ADDR_W*p +: ADDR_W] = adr;
        d_elem[ELEM_W*p +: ELEM_W]    = elem;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (d_gnt !== 4'b0)       begin errors++; $display("FAIL reset_gnt: got %b want 0000", d_gnt); end
        checks++; if (d_douten !== 4'b0)    begin errors++; $display("FAIL reset_douten: got %b want 0000", d_douten); end
        checks++; if (d_busy !== 4'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0000", d_busy); end
        checks++; if (d_dout !== {DATA_W{1'b0}}) begin errors++; $display("FAIL reset_dout: got %h want 0", d_dout); end
        checks++; if (app_addr !== 28'h0)   begin errors++; $display("FAIL reset_addr: got %h want 0", app_addr); end
        checks++; if (app_cmd !== 3'd0)     begin errors++; $display("FAIL reset_cmd: got %0d want 0", app_cmd); end
        checks++; if ({app_en, app_wdf_wren, d_w} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got en=%b wren=%b dw=%b want 0", app_en, app_wdf_wren, d_w); end
        rst = 1'b0;
    endtask

    // Read burst with returns that start while commands are still issuing
    task automatic run_read(input string nm, input int p, input logic [ADDR_W-1:0] base,
                            input int n, input logic [ADDR_W-1:0] exp_a0,
                            input logic [ADDR_W-1:0] exp_a1, input logic [ADDR_W-1:0] exp_a2,
                            input logic [ADDR_W-1:0] exp_a3);
        logic [ADDR_W-1:0] addrs [$];
        logic [ADDR_W-1:0] exp_a [4];
        logic [ADDR_W-1:0] got;
        logic [NPORT-1:0]  own;
        int rcv = 0;
        int sent = 0;
        exp_a[0] = exp_a0; exp_a[1] = exp_a1; exp_a[2] = exp_a2; exp_a[3] = exp_a3;
        own = 4'b0001 << p;
        app_rdy = 1'b1;
        set_port(p, 2'd1, base, ELEM_W'(n));
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (d_gnt !== own) begin errors++; $display("FAIL %s_gnt: got %b want %b", nm, d_gnt, own); end
                checks++; if (app_cmd !== 3'd1) begin errors++; $display("FAIL %s_cmd: got %0d want 1", nm, app_cmd); end
                checks++; if (d_busy !== own) begin errors++; $display("FAIL %s_busy: got %b want %b", nm, d_busy, own); end
            end
            if (d_gnt[p]) d_req[2*p +: 2] = 2'd0;
            if (app_en && app_rdy) addrs.push_back(app_addr);
            if (d_douten !== 4'b0) begin
                checks++;
                if (d_douten !== own || d_dout !== pat(32'hD000_0000 + 32'(rcv))) begin
                    errors++; $display("FAIL %s_ret%0d: got en=%b data=%h want en=%b", nm, rcv, d_douten, d_dout[31:0], own);
                end
                rcv++;
            end
            if (c >= 2 && sent < n) begin
                app_rd_data_valid = 1'b1;
                app_rd_data = pat(32'hD000_0000 + 32'(sent));
                sent++;
            end else begin
                app_rd_data_valid = 1'b0;
            end
        end
        checks++; if (addrs.size() != n) begin errors++; $display("FAIL %s_ncmd: got %0d want %0d", nm, addrs.size(), n); end
        for (int i = 0; i < n; i++) begin
            got = (i < addrs.size()) ? addrs[i] : 28'hxxxxxxx;
            checks++; if (got !== exp_a[i]) begin errors++; $display("FAIL %s_addr%0d: got %h want %h", nm, i, got, exp_a[i]); end
        end
        checks++; if (rcv != n) begin errors++; $display("FAIL %s_nret: got %0d want %0d", nm, rcv, n); end
        checks++; if (d_busy !== 4'b0) begin errors++; $display("FAIL %s_busy_end: got %b want 0000", nm, d_busy); end
    endtask

    task automatic test_read;
        run_read("read", 2, 28'h100, 4, 28'h100, 28'h108, 28'h110, 28'h118);
    endtask

    task automatic test_wrap;
        run_read("wrap", 1, LAST - 28'h8, 3, LAST - 28'h8, LAST, 28'h0, 28'h0);
    endtask

    task automatic test_write;
        int nw = 0;
        logic fire_exp;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        d_din[0 +: DATA_W] = pat(32'hE000_0000);
        set_port(0, 2'd2, 28'h200, 32'd3);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (d_gnt !== 4'b0001) begin errors++; $display("FAIL write_gnt: got %b want 0001", d_gnt); end
                checks++; if (app_cmd !== 3'd0) begin errors++; $display("FAIL write_cmd: got %0d want 0", app_cmd); end
            end
            if (d_gnt[0]) d_req[1:0] = 2'd0;
            fire_exp = (c == 1) || (c == 3) || (c == 5);
            checks++;
            if (d_w !== (fire_exp ? 4'b0001 : 4'b0000) || app_en !== fire_exp ||
                app_wdf_wren !== fire_exp || app_wdf_end !== fire_exp) begin
                errors++; $display("FAIL write_strobe_c%0d: got dw=%b en=%b wren=%b end=%b want fire=%b", c, d_w, app_en, app_wdf_wren, app_wdf_end, fire_exp);
            end
            if (d_w[0]) begin
                checks++;
                if (app_wdf_data !== pat(32'hE000_0000 + 32'(nw)) || app_addr !== 28'h200 + 28'(8 * nw)) begin
                    errors++; $display("FAIL write_beat%0d: got data=%h addr=%h", nw, app_wdf_data[31:0], app_addr);
                end
                nw++;
                d_din[0 +: DATA_W] = pat(32'hE000_0000 + 32'(nw));
            end
            app_wdf_rdy = (c + 1 > 5) ? 1'b1 : (((c + 1) % 2) == 1);
        end
        checks++; if (nw != 3) begin errors++; $display("FAIL write_count: got %0d want 3", nw); end
        checks++; if (d_busy !== 4'b0) begin errors++; $display("FAIL write_busy_end: got %b want 0000", d_busy); end
    endtask

    task automatic test_round_robin;
        int order [$];
        int exp_o [5] = '{0, 1, 2, 3, 0};
        int got;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        for (int p = 0; p < NPORT; p++) set_port(p, 2'd2, 28'(32'h1000 * p), 32'd1);
        for (int c = 1; c <= 30 && order.size() < 5; c++) begin
            @(negedge clk);
            if (d_gnt !== 4'b0) begin
                checks++; if (!$onehot(d_gnt)) begin errors++; $display("FAIL rr_onehot: got %b", d_gnt); end
                for (int p = 0; p < NPORT; p++) begin
                    if (d_gnt[p]) begin
                        order.push_back(p);
                        d_req[2*p +: 2] = 2'd0;
                    end
                end
                if (order.size() == 4) begin
                    d_req[1:0] = 2'd2;
                    d_req[3:2] = 2'd2;
                end
            end
        end
        d_req = '0;
        checks++; if (order.size() != 5) begin errors++; $display("FAIL rr_count: got %0d want 5", order.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < order.size()) ? order[i] : -1;
            checks++; if (got != exp_o[i]) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", i, got, exp_o[i]); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_zero_elem;
        int gcount = 0;
        int en_seen = 0;
        int busy_seen = 0;
        set_port(1, 2'd2, 28'h300, 32'd0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (d_gnt !== 4'b0) begin
                checks++; if (d_gnt !== 4'b0010) begin errors++; $display("FAIL zero_gnt: got %b want 0010", d_gnt); end
                gcount++;
                d_req[3:2] = 2'd0;
            end
            if (app_en) en_seen++;
            if (d_busy !== 4'b0) busy_seen++;
        end
        checks++; if (gcount != 1) begin errors++; $display("FAIL zero_gcount: got %0d want 1", gcount); end
        checks++; if (en_seen != 0) begin errors++; $display("FAIL zero_app_en: got %0d cycles want 0", en_seen); end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL zero_busy: got %0d cycles want 0", busy_seen); end
    endtask

    task automatic test_reset_mid_burst;
        app_rdy = 1'b1;
        set_port(3, 2'd1, 28'h40, 32'd5);
        @(negedge clk);
        checks++; if (d_gnt !== 4'b1000) begin errors++; $display("FAIL mid_gnt: got %b want 1000", d_gnt); end
        d_req[7:6] = 2'd0;
        @(negedge clk);
        app_rd_data_valid = 1'b1;
        app_rd_data = pat(32'hF000_0000);
        @(negedge clk);
        checks++; if (d_douten !== 4'b1000 || d_dout !== pat(32'hF000_0000)) begin errors++; $display("FAIL mid_ret0: got en=%b data=%h", d_douten, d_dout[31:0]); end
        app_rd_data = pat(32'hF000_0001);
        @(negedge clk);
        checks++; if (d_douten !== 4'b1000 || d_dout !== pat(32'hF000_0001)) begin errors++; $display("FAIL mid_ret1: got en=%b data=%h", d_douten, d_dout[31:0]); end
        app_rd_data_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({d_gnt, d_douten, d_busy, d_w} !== 16'b0 || d_dout !== {DATA_W{1'b0}} || app_addr !== 28'h0 ||
            app_cmd !== 3'd0 || app_en !== 1'b0 || app_wdf_wren !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got gnt=%b douten=%b busy=%b addr=%h cmd=%0d en=%b want all 0", d_gnt, d_douten, d_busy, app_addr, app_cmd, app_en);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = pat(32'hF000_0002 + 32'(k));
            @(negedge clk);
            checks++; if (d_douten !== 4'b0 || d_busy !== 4'b0) begin errors++; $display("FAIL mid_drop%0d: got douten=%b busy=%b want 0000", k, d_douten, d_busy); end
        end
        app_rd_data_valid = 1'b0;
        @(negedge clk);
        checks++; if (d_douten !== 4'b0) begin errors++; $display("FAIL mid_drop_tail: got %b want 0000", d_douten); end
    endtask

    initial begin
        rst = 1'b1;
        d_req = '0;
        d_initadr = '0;
        d_elem = '0;
        d_din = '0;
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_wrap();
        test_zero_elem();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
